// File: rtl/vproc_fpu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vproc_fpu_arbiter
// Purpose  : Shares one pipelined, in-order FP unit between NREQ requesters.
//            The issue grant is round-robin. A stalled issue is locked to its
//            requester until it is accepted. The ID of every issued operation
//            is kept in an in-order FIFO, so each returned result is steered
//            back to the requester that issued it.
// Ports    : clk_i / async_rst_i   clock, asynchronous active-high reset
//            flush_i               drop all in-flight bookkeeping
//            req_*                 per-requester issue channel (sliced buses)
//            fpu_* (issue)         muxed issue channel towards the FP unit
//            fpu_res_*/status      result channel from the FP unit
//            rsp_*                 one-hot result valid, shared result bus
//            outst_cnt_o           operations currently in flight
//            err_o                 sticky: result seen with nothing in flight
// Revision : 1.0  initial release
// ============================================================================
module vproc_fpu_arbiter #(
  parameter int NREQ      = 2,
  parameter int OP_W      = 32,
  parameter int CTRL_W    = 16,
  parameter int MAX_OUTST = 4
) (
  input  logic                          clk_i,
  input  logic                          async_rst_i,
  input  logic                          flush_i,
  input  logic [NREQ-1:0]               req_valid_i,
  output logic [NREQ-1:0]               req_ready_o,
  input  logic [NREQ*OP_W-1:0]          req_op1_i,
  input  logic [NREQ*OP_W-1:0]          req_op2_i,
  input  logic [NREQ*OP_W-1:0]          req_op3_i,
  input  logic [NREQ*CTRL_W-1:0]        req_ctrl_i,
  output logic                          fpu_valid_o,
  input  logic                          fpu_ready_i,
  output logic [OP_W-1:0]               fpu_op1_o,
  output logic [OP_W-1:0]               fpu_op2_o,
  output logic [OP_W-1:0]               fpu_op3_o,
  output logic [CTRL_W-1:0]             fpu_ctrl_o,
  input  logic                          fpu_res_valid_i,
  output logic                          fpu_res_ready_o,
  input  logic [OP_W-1:0]               fpu_res_i,
  input  logic [4:0]                    fpu_status_i,
  output logic [NREQ-1:0]               rsp_valid_o,
  input  logic [NREQ-1:0]               rsp_ready_i,
  output logic [OP_W-1:0]               rsp_res_o,
  output logic [4:0]                    rsp_status_o,
  output logic [$clog2(MAX_OUTST):0]    outst_cnt_o,
  output logic                          err_o
);

  localparam int ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int CNT_W = $clog2(MAX_OUTST) + 1;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTST - 1)) ? '0 : p + 1'b1;
  endfunction

  // State
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic             lock_q, lock_d;
  logic [ID_W-1:0]  locked_id_q, locked_id_d;
  logic [ID_W-1:0]  fifo_q [MAX_OUTST];
  logic [ID_W-1:0]  fifo_d [MAX_OUTST];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // Combinational
  logic [ID_W-1:0]  grant_id;
  logic             grant_vld;
  logic             issue_ok;
  logic             accept;
  logic             pop;
  logic             nonempty;
  logic [ID_W-1:0]  head_id;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge async_rst_i) begin
    if (async_rst_i) begin
      rr_ptr_q    <= '0;
      lock_q      <= 1'b0;
      locked_id_q <= '0;
      fifo_q      <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      lock_q      <= lock_d;
      locked_id_q <= locked_id_d;
      fifo_q      <= fifo_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
    end
  end

  // --------------------------------------------------------------------------
  // Grant: a stalled issue stays pinned to its requester; otherwise search
  // forward from rr_ptr for the first valid requester.
  // --------------------------------------------------------------------------
  always_comb begin
    int          idx;
    logic [ID_W-1:0] cand;
    grant_id  = rr_ptr_q;
    grant_vld = 1'b0;
    idx       = 0;
    cand      = '0;
    if (lock_q) begin
      grant_id  = locked_id_q;
      grant_vld = req_valid_i[locked_id_q];
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        idx = int'(rr_ptr_q) + k;
        if (idx >= NREQ) idx = idx - NREQ;
        cand = ID_W'(idx);
        if (!grant_vld && req_valid_i[cand]) begin
          grant_id  = cand;
          grant_vld = 1'b1;
        end
      end
    end
  end

  assign nonempty = (cnt_q != '0);
  assign head_id  = fifo_q[rd_ptr_q];

  // Holding reset also keeps the issue handshake quiet, so nothing is
  // accepted while the bookkeeping is being cleared.
  assign issue_ok = (cnt_q < CNT_W'(MAX_OUTST)) & ~flush_i & ~async_rst_i;
  assign accept   = fpu_valid_o & fpu_ready_i;
  assign pop      = fpu_res_valid_i & fpu_res_ready_o;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    lock_d      = lock_q;
    locked_id_d = locked_id_q;
    fifo_d      = fifo_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    // A result with nothing in flight can never be routed: flag it forever.
    err_d       = err_q | (fpu_res_valid_i & ~nonempty);

    if (flush_i) begin
      // rr_ptr is intentionally kept so fairness survives a flush.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      lock_d   = 1'b0;
    end else begin
      if (accept) begin
        fifo_d[wr_ptr_q] = grant_id;
        wr_ptr_d         = ptr_inc(wr_ptr_q);
        lock_d           = 1'b0;
        rr_ptr_d         = (grant_id == ID_W'(NREQ - 1)) ? '0 : grant_id + 1'b1;
      end else if (fpu_valid_o) begin
        lock_d      = 1'b1;
        locked_id_d = grant_id;
      end
      if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      cnt_d = cnt_q + CNT_W'(accept) - CNT_W'(pop);
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  always_comb begin
    fpu_valid_o     = issue_ok & grant_vld;
    fpu_op1_o       = '0;
    fpu_op2_o       = '0;
    fpu_op3_o       = '0;
    fpu_ctrl_o      = '0;
    if (grant_vld) begin
      fpu_op1_o  = req_op1_i[int'(grant_id)*OP_W +: OP_W];
      fpu_op2_o  = req_op2_i[int'(grant_id)*OP_W +: OP_W];
      fpu_op3_o  = req_op3_i[int'(grant_id)*OP_W +: OP_W];
      fpu_ctrl_o = req_ctrl_i[int'(grant_id)*CTRL_W +: CTRL_W];
    end
    req_ready_o = '0;
    rsp_valid_o = '0;
    for (int r = 0; r < NREQ; r++) begin
      req_ready_o[r] = accept & (grant_id == ID_W'(r));
      rsp_valid_o[r] = fpu_res_valid_i & nonempty & (head_id == ID_W'(r));
    end
    fpu_res_ready_o = rsp_ready_i[head_id] & nonempty;
  end

  assign rsp_res_o    = fpu_res_i;
  assign rsp_status_o = fpu_status_i;
  assign outst_cnt_o  = cnt_q;
  assign err_o        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_vproc_fpu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vproc_fpu_arbiter
// Purpose  : Self-checking bench for vproc_fpu_arbiter (NREQ=2, MAX_OUTST=4):
//            table of per-cycle vectors, hand-written full/flush sequences and
//            a random run checked against a small reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_vproc_fpu_arbiter;

  localparam int NREQ = 2;
  localparam int OP_W = 32;
  localparam int CTRL_W = 16;
  localparam int MAX_OUTST = 4;

  logic                   clk_i = 1'b0;
  logic                   async_rst_i;
  logic                   flush_i;
  logic [NREQ-1:0]        req_valid_i;
  logic [NREQ-1:0]        req_ready_o;
  logic [NREQ*OP_W-1:0]   req_op1_i, req_op2_i, req_op3_i;
  logic [NREQ*CTRL_W-1:0] req_ctrl_i;
  logic                   fpu_valid_o;
  logic                   fpu_ready_i;
  logic [OP_W-1:0]        fpu_op1_o, fpu_op2_o, fpu_op3_o;
  logic [CTRL_W-1:0]      fpu_ctrl_o;
  logic                   fpu_res_valid_i;
  logic                   fpu_res_ready_o;
  logic [OP_W-1:0]        fpu_res_i;
  logic [4:0]             fpu_status_i;
  logic [NREQ-1:0]        rsp_valid_o;
  logic [NREQ-1:0]        rsp_ready_i;
  logic [OP_W-1:0]        rsp_res_o;
  logic [4:0]             rsp_status_o;
  logic [2:0]             outst_cnt_o;
  logic                   err_o;

  vproc_fpu_arbiter #(
    .NREQ(NREQ), .OP_W(OP_W), .CTRL_W(CTRL_W), .MAX_OUTST(MAX_OUTST)
  ) dut (
    .clk_i(clk_i), .async_rst_i(async_rst_i), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_op1_i(req_op1_i), .req_op2_i(req_op2_i), .req_op3_i(req_op3_i),
    .req_ctrl_i(req_ctrl_i),
    .fpu_valid_o(fpu_valid_o), .fpu_ready_i(fpu_ready_i),
    .fpu_op1_o(fpu_op1_o), .fpu_op2_o(fpu_op2_o), .fpu_op3_o(fpu_op3_o),
    .fpu_ctrl_o(fpu_ctrl_o),
    .fpu_res_valid_i(fpu_res_valid_i), .fpu_res_ready_o(fpu_res_ready_o),
    .fpu_res_i(fpu_res_i), .fpu_status_i(fpu_status_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_res_o(rsp_res_o), .rsp_status_o(rsp_status_o),
    .outst_cnt_o(outst_cnt_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  // Per-requester constant payloads; the control word identifies the grant.
  localparam logic [15:0] CTRL0 = 16'hA000;
  localparam logic [15:0] CTRL1 = 16'hB001;
  localparam logic [31:0] RES   = 32'h3F80_0000;

  typedef struct {
    logic [1:0]  rv;
    logic        fr;
    logic        resv;
    logic [1:0]  rspr;
    logic        flush;
    logic [1:0]  e_rdy;
    logic        e_fv;
    logic [15:0] e_ctrl;
    logic [1:0]  e_rspv;
    logic        e_resrdy;
    logic [2:0]  e_cnt;
    logic        e_err;
  } vec_t;

  localparam int NVEC = 22;
  vec_t tbl [NVEC];

  int n_cmp = 0;
  int n_bad = 0;

  // random-run model state
  int          m_rr, m_lid, g, idx, ops, cyc, acc;
  bit          m_lock;
  int          q [$];
  logic [1:0]  pend, e_rdy, e_rspv, e_mask;
  logic        e_fv, e_resrdy;
  logic [31:0] e_op;

  function automatic vec_t mk(logic [1:0] rv, logic fr, logic resv, logic [1:0] rspr,
                              logic flush, logic [1:0] e_rdy, logic e_fv,
                              logic [15:0] e_ctrl, logic [1:0] e_rspv, logic e_resrdy,
                              logic [2:0] e_cnt, logic e_err);
    vec_t v;
    v.rv = rv; v.fr = fr; v.resv = resv; v.rspr = rspr; v.flush = flush;
    v.e_rdy = e_rdy; v.e_fv = e_fv; v.e_ctrl = e_ctrl; v.e_rspv = e_rspv;
    v.e_resrdy = e_resrdy; v.e_cnt = e_cnt; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] rv, input logic fr, input logic resv,
                       input logic [1:0] rspr, input logic flush);
    req_valid_i     = rv;
    fpu_ready_i     = fr;
    fpu_res_valid_i = resv;
    rsp_ready_i     = rspr;
    flush_i         = flush;
  endtask

  task automatic adv();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    req_op1_i  = {32'h1100_0001, 32'h1100_0000};
    req_op2_i  = {32'h2200_0001, 32'h2200_0000};
    req_op3_i  = {32'h3300_0001, 32'h3300_0000};
    req_ctrl_i = {CTRL1, CTRL0};
    fpu_res_i    = RES;
    fpu_status_i = 5'h01;
    drive(2'b00, 1'b0, 1'b0, 2'b00, 1'b0);

    //            rv    fr resv rspr  fl   rdy  fv ctrl   rspv  rr cnt err
    // both requesters streaming, results two cycles behind
    tbl[0]  = mk(2'b11, 1, 0, 2'b11, 0, 2'b01, 1, CTRL0, 2'b00, 0, 0, 0);
    tbl[1]  = mk(2'b11, 1, 0, 2'b11, 0, 2'b10, 1, CTRL1, 2'b00, 1, 1, 0);
    tbl[2]  = mk(2'b11, 1, 1, 2'b11, 0, 2'b01, 1, CTRL0, 2'b01, 1, 2, 0);
    tbl[3]  = mk(2'b11, 1, 1, 2'b11, 0, 2'b10, 1, CTRL1, 2'b10, 1, 2, 0);
    tbl[4]  = mk(2'b11, 1, 1, 2'b11, 0, 2'b01, 1, CTRL0, 2'b01, 1, 2, 0);
    tbl[5]  = mk(2'b11, 1, 1, 2'b11, 0, 2'b10, 1, CTRL1, 2'b10, 1, 2, 0);
    tbl[6]  = mk(2'b00, 1, 1, 2'b11, 0, 2'b00, 0, 16'h0, 2'b01, 1, 2, 0);
    tbl[7]  = mk(2'b00, 1, 1, 2'b11, 0, 2'b00, 0, 16'h0, 2'b10, 1, 1, 0);
    tbl[8]  = mk(2'b00, 1, 0, 2'b11, 0, 2'b00, 0, 16'h0, 2'b00, 0, 0, 0);
    // req1 stalled three cycles, req0 joins; grant stays locked on req1
    tbl[9]  = mk(2'b10, 0, 0, 2'b00, 0, 2'b00, 1, CTRL1, 2'b00, 0, 0, 0);
    tbl[10] = mk(2'b11, 0, 0, 2'b00, 0, 2'b00, 1, CTRL1, 2'b00, 0, 0, 0);
    tbl[11] = mk(2'b11, 0, 0, 2'b00, 0, 2'b00, 1, CTRL1, 2'b00, 0, 0, 0);
    tbl[12] = mk(2'b11, 1, 0, 2'b00, 0, 2'b10, 1, CTRL1, 2'b00, 0, 0, 0);
    tbl[13] = mk(2'b01, 1, 0, 2'b00, 0, 2'b01, 1, CTRL0, 2'b00, 0, 1, 0);
    // head ID 1 result held while its requester is not ready
    tbl[14] = mk(2'b00, 1, 1, 2'b01, 0, 2'b00, 0, 16'h0, 2'b10, 0, 2, 0);
    tbl[15] = mk(2'b00, 1, 1, 2'b01, 0, 2'b00, 0, 16'h0, 2'b10, 0, 2, 0);
    tbl[16] = mk(2'b00, 1, 1, 2'b11, 0, 2'b00, 0, 16'h0, 2'b10, 1, 2, 0);
    tbl[17] = mk(2'b00, 1, 1, 2'b01, 0, 2'b00, 0, 16'h0, 2'b01, 1, 1, 0);
    tbl[18] = mk(2'b00, 1, 0, 2'b00, 0, 2'b00, 0, 16'h0, 2'b00, 0, 0, 0);
    // result with nothing in flight: sticky error from the next cycle
    tbl[19] = mk(2'b00, 1, 1, 2'b11, 0, 2'b00, 0, 16'h0, 2'b00, 0, 0, 0);
    tbl[20] = mk(2'b00, 1, 0, 2'b00, 0, 2'b00, 0, 16'h0, 2'b00, 0, 0, 1);
    tbl[21] = mk(2'b00, 1, 0, 2'b00, 0, 2'b00, 0, 16'h0, 2'b00, 0, 0, 1);

    // ---------------- reset ----------------
    async_rst_i = 1'b1;
    #12;
    chk("rst req_ready", req_ready_o, 2'b00);
    chk("rst fpu_valid", fpu_valid_o, 1'b0);
    chk("rst res_ready", fpu_res_ready_o, 1'b0);
    chk("rst rsp_valid", rsp_valid_o, 2'b00);
    chk("rst outst_cnt", outst_cnt_o, 3'd0);
    chk("rst err", err_o, 1'b0);
    @(negedge clk_i);
    async_rst_i = 1'b0;
    adv();

    // ---------------- table ----------------
    for (int i = 0; i < NVEC; i++) begin
      drive(tbl[i].rv, tbl[i].fr, tbl[i].resv, tbl[i].rspr, tbl[i].flush);
      @(negedge clk_i);
      chk($sformatf("row%0d req_ready", i), req_ready_o, tbl[i].e_rdy);
      chk($sformatf("row%0d fpu_valid", i), fpu_valid_o, tbl[i].e_fv);
      chk($sformatf("row%0d fpu_ctrl", i), fpu_ctrl_o, tbl[i].e_ctrl);
      e_op = (tbl[i].e_ctrl == CTRL0) ? 32'h1100_0000 :
             (tbl[i].e_ctrl == CTRL1) ? 32'h1100_0001 : 32'h0;
      chk($sformatf("row%0d fpu_op1", i), fpu_op1_o, e_op);
      chk($sformatf("row%0d fpu_op3", i), fpu_op3_o, (e_op == 32'h0) ? 32'h0 : e_op + 32'h2200_0000);
      chk($sformatf("row%0d rsp_valid", i), rsp_valid_o, tbl[i].e_rspv);
      chk($sformatf("row%0d res_ready", i), fpu_res_ready_o, tbl[i].e_resrdy);
      chk($sformatf("row%0d outst_cnt", i), outst_cnt_o, tbl[i].e_cnt);
      chk($sformatf("row%0d err", i), err_o, tbl[i].e_err);
      if (tbl[i].e_rspv != 2'b00) begin
        chk($sformatf("row%0d rsp_res", i), rsp_res_o, RES);
        chk($sformatf("row%0d rsp_status", i), rsp_status_o, 5'h01);
      end
      adv();
    end

    // ---------------- full: 4 accepts, then stop, no same-cycle bypass ----------------
    drive(2'b11, 1, 0, 2'b11, 0);
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      if (req_ready_o != 2'b00) acc++;
      adv();
    end
    chk("full accepts", 64'(acc), 64'd4);
    @(negedge clk_i);
    chk("full fpu_valid", fpu_valid_o, 1'b0);
    chk("full outst_cnt", outst_cnt_o, 3'd4);
    adv();
    drive(2'b11, 1, 1, 2'b11, 0);
    @(negedge clk_i);
    chk("full pop no-bypass fpu_valid", fpu_valid_o, 1'b0);
    chk("full pop rsp_valid", rsp_valid_o, 2'b10);
    adv();
    drive(2'b11, 1, 0, 2'b11, 0);
    @(negedge clk_i);
    chk("full 5th fpu_valid", fpu_valid_o, 1'b1);
    chk("full 5th ctrl", fpu_ctrl_o, CTRL1);
    chk("full 5th outst_cnt", outst_cnt_o, 3'd3);
    adv();

    // ---------------- flush with cnt=3, rr_ptr=1 ----------------
    drive(2'b00, 1, 1, 2'b11, 0);
    @(negedge clk_i);
    chk("pre-flush pop rsp_valid", rsp_valid_o, 2'b01);
    adv();
    drive(2'b11, 1, 0, 2'b11, 0);
    @(negedge clk_i);
    chk("pre-flush issue ctrl", fpu_ctrl_o, CTRL0);
    adv();
    drive(2'b00, 1, 1, 2'b11, 0);
    @(negedge clk_i);
    adv();
    drive(2'b11, 1, 0, 2'b11, 1);
    @(negedge clk_i);
    chk("flush fpu_valid", fpu_valid_o, 1'b0);
    chk("flush req_ready", req_ready_o, 2'b00);
    chk("flush outst_cnt", outst_cnt_o, 3'd3);
    adv();
    drive(2'b11, 1, 0, 2'b11, 0);
    @(negedge clk_i);
    chk("post-flush outst_cnt", outst_cnt_o, 3'd0);
    chk("post-flush rr ctrl", fpu_ctrl_o, CTRL1);
    chk("post-flush fpu_valid", fpu_valid_o, 1'b1);
    chk("post-flush err sticky", err_o, 1'b1);
    adv();

    // ---------------- reset mid-operation ----------------
    drive(2'b00, 0, 0, 2'b00, 0);
    async_rst_i = 1'b1;
    #3;
    chk("rst2 err", err_o, 1'b0);
    chk("rst2 outst_cnt", outst_cnt_o, 3'd0);
    @(negedge clk_i);
    async_rst_i = 1'b0;
    adv();

    // ---------------- random ops against a reference model ----------------
    m_rr = 0; m_lock = 0; m_lid = 0; pend = 2'b00; ops = 0; cyc = 0;
    q.delete();
    while (ops < 1000 && cyc < 20000) begin
      cyc++;
      for (int r = 0; r < NREQ; r++)
        if (((pend >> r) & 2'b01) == 2'b00 && $urandom_range(0, 1) == 1)
          pend = pend | 2'(1 << r);
      req_valid_i     = pend;
      fpu_ready_i     = ($urandom_range(0, 3) != 0);
      rsp_ready_i     = 2'($urandom);
      fpu_res_valid_i = (q.size() > 0) && ($urandom_range(0, 1) == 1);
      flush_i         = 1'b0;

      g = -1;
      if (m_lock) g = m_lid;
      else
        for (int k = 0; k < NREQ; k++) begin
          idx = (m_rr + k) % NREQ;
          if (g < 0 && ((pend >> idx) & 2'b01) != 2'b00) g = idx;
        end
      e_fv   = (g >= 0) && (q.size() < MAX_OUTST);
      e_rdy  = (e_fv && fpu_ready_i) ? 2'(1 << g) : 2'b00;
      e_rspv = 2'b00;
      e_resrdy = 1'b0;
      if (q.size() > 0) begin
        e_mask   = 2'(1 << q[0]);
        e_resrdy = |(rsp_ready_i & e_mask);
        if (fpu_res_valid_i) e_rspv = e_mask;
      end

      @(negedge clk_i);
      chk($sformatf("rnd cyc%0d rdy/fv/rspv/resrdy/cnt", cyc),
          {req_ready_o, fpu_valid_o, rsp_valid_o, fpu_res_ready_o, outst_cnt_o},
          {e_rdy, e_fv, e_rspv, e_resrdy, 3'(q.size())});

      if (fpu_res_valid_i && e_resrdy) void'(q.pop_front());
      if (e_rdy != 2'b00) begin
        q.push_back(g);
        pend   = pend & ~e_rdy;
        m_rr   = (g + 1) % NREQ;
        m_lock = 0;
        ops++;
      end else if (e_fv) begin
        m_lock = 1;
        m_lid  = g;
      end
      adv();
    end
    chk("rnd ops completed", 64'(ops), 64'd1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vproc_fpu_arbiter.md
Name: vproc_fpu_arbiter

Overview:
- Shares one pipelined in-order FP unit between NREQ requesters, for example the vector FPU lane and a scalar-offload port.
- Arbitrates issue round-robin and keeps valid/data stable during backpressure.
- Records the requester ID of every issued operation in an in-order ID FIFO. Each result returned by the FP unit is routed back to the requester that issued it.
- Sits between the requesters' issue stages and the FP unit wrapper.

Parameters:
NREQ, 2, number of requesters (2..4)
OP_W, 32, operand/result width in bits
CTRL_W, 16, opaque per-operation control word width (op, op_mod, rnd_mode, formats), passed through unchanged
MAX_OUTST, 4, maximum operations in flight inside the FP unit; power of 2

Ports:
clk_i  in  1  clock
async_rst_i  in  1  asynchronous reset, active-high
flush_i  in  1  synchronous flush of in-flight bookkeeping
req_valid_i  in  NREQ  per-requester request valid
req_ready_o  out  NREQ  per-requester request accepted
req_op1_i/req_op2_i/req_op3_i  in  NREQ*OP_W  operands; requester r occupies slice [r*OP_W +: OP_W]
req_ctrl_i  in  NREQ*CTRL_W  control word per requester
fpu_valid_o  out  1  issue valid to FP unit
fpu_ready_i  in  1  FP unit accepts issue
fpu_op1_o/fpu_op2_o/fpu_op3_o  out  OP_W  muxed operands
fpu_ctrl_o  out  CTRL_W  muxed control word
fpu_res_valid_i  in  1  FP unit result valid
fpu_res_ready_o  out  1  result consumed
fpu_res_i  in  OP_W  result
fpu_status_i  in  5  fflags (NV,DZ,OF,UF,NX)
rsp_valid_o  out  NREQ  one-hot result valid to the owning requester
rsp_ready_i  in  NREQ  per-requester result ready
rsp_res_o  out  OP_W  shared result bus
rsp_status_o  out  5  shared status bus
outst_cnt_o  out  $clog2(MAX_OUTST)+1  operations in flight
err_o  out  1  sticky protocol error

Behaviour:
Reset (async_rst_i high, asynchronous):
- Outputs: req_ready_o=0, fpu_valid_o=0, fpu_res_ready_o=0, rsp_valid_o=0, outst_cnt_o=0, err_o=0.
- State: rr_ptr=0, lock=0, FIFO empty.
- Reset mid-operation discards all in-flight IDs. The FP unit is reset by the same source.

Grant:
- Combinational. No added latency on the issue path.
- When lock=0, the grant goes to the first r with req_valid_i[r], searching r = rr_ptr, rr_ptr+1, ... modulo NREQ.

Issue gating:
- issue_ok = (outst_cnt < MAX_OUTST) and not flush_i.
- fpu_valid_o = issue_ok and the granted requester is valid.
- fpu_op*/fpu_ctrl_o = slices of the granted requester. They are 0 when nothing is granted.

Accept and lock:
- req_ready_o[g] = fpu_valid_o & fpu_ready_i, for the granted g only.
- On accept: push g into the ID FIFO; rr_ptr <= (g+1) mod NREQ; lock <= 0.
- If fpu_valid_o=1 and fpu_ready_i=0: lock <= 1 and locked_id <= g.
- While lock=1 the grant is forced to locked_id, so the request is never withdrawn or re-arbitrated.
- Requesters must hold valid/data until ready (AXI-style rule).

Full condition:
- Issue is blocked when outst_cnt == MAX_OUTST, even if a pop occurs the same cycle. There is no bypass.

Response path:
- head = FIFO head ID.
- rsp_valid_o[head] = fpu_res_valid_i & (cnt != 0). All other bits are 0.
- fpu_res_ready_o = rsp_ready_i[head] & (cnt != 0).
- rsp_res_o = fpu_res_i and rsp_status_o = fpu_status_i, unregistered.
- Pop on fpu_res_valid_i & fpu_res_ready_o.

Counter:
- cnt_next = cnt + push - pop.
- A simultaneous push and pop leaves cnt unchanged. The FIFO pointers wrap modulo MAX_OUTST.

Error:
- fpu_res_valid_i=1 while cnt=0 sets err_o (sticky until reset).
- In that case fpu_res_ready_o=0 and rsp_valid_o=0.

Flush:
- flush_i=1 in a cycle blocks issue that cycle.
- On the next edge: FIFO and cnt cleared, lock=0. rr_ptr is retained.
- Responses arriving after the flush raise err_o unless the FP unit is flushed concurrently.

Invariants:
- fpu_valid_o never drops while lock=1 unless a flush or reset occurs.
- At most one rsp_valid_o bit is high.

Test Plan:
- Reset, then req_valid_i=2'b11 continuously with fpu_ready_i=1 and results returned 2 cycles later → grants alternate 0,1,0,1. rsp_valid_o follows 01,10,01,10. outst_cnt_o stays at 2.
- Requester 1 valid with fpu_ready_i=0 for 3 cycles; requester 0 becomes valid on cycle 2 → fpu_ctrl_o stays req1's control word all 3 cycles. The grant moves to req0 only after req1 is accepted.
- MAX_OUTST=4, fpu_res_valid_i=0, both requesters valid → exactly 4 accepts, then fpu_valid_o=0 and outst_cnt_o=4. One result pop with rsp_ready_i=1 allows the 5th issue on the following cycle, not the same cycle.
- Result 0x3F800000 with head ID=1 and rsp_ready_i[1]=0 for 2 cycles → rsp_valid_o=2'b10 is held, fpu_res_ready_o=0, and there is no pop until ready.
- Simultaneous accept and pop at cnt=2 → cnt stays 2 and the FIFO order is preserved (IDs check against a scoreboard over 1000 random ops).
- fpu_res_valid_i=1 at cnt=0 → err_o=1 the next cycle and remains 1. Then flush_i pulse with cnt=3 → outst_cnt_o=0, rr_ptr unchanged.
